// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller:
// operand-select encoding and the per-stage destination record.
package hazard_fwd_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_rec_t;

  // A record can supply a value only if it
  // really writes a register other than r0.
  function automatic logic producer(
    input stage_rec_t r
  );
    return r.valid & r.regwrite &
           (r.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-side request and EX-side control bundle.
// master: decode stage drives id_*/flush_i; slave: controller.
interface hazard_fwd_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              flush_i;
  logic              stall_o;
  logic [1:0]        fwd_a_sel_o;
  logic [1:0]        fwd_b_sel_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i,
    output id_use_rs_i, id_use_rt_i,
    output id_rd_i, id_regwrite_i,
    output id_memread_i, flush_i,
    input  stall_o, fwd_a_sel_o,
    input  fwd_b_sel_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i,
    input  id_use_rs_i, id_use_rt_i,
    input  id_rd_i, id_regwrite_i,
    input  id_memread_i, flush_i,
    output stall_o, fwd_a_sel_o,
    output fwd_b_sel_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// One source operand vs. EX/MEM records: mux select + load-use hit.
// Ports: src, use_src, ex, mem in; sel, lu_hit out.
module fwd_match
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic [REG_AW_DEF-1:0] src,
  input  logic                  use_src,
  input  stage_rec_t            ex,
  input  stage_rec_t            mem,
  output logic [1:0]            sel,
  output logic                  lu_hit
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = use_src & producer(ex) &
                   (ex.rd == src);
  assign mem_hit = use_src & producer(mem) &
                   (mem.rd == src);
  assign lu_hit  = ex_hit & ex.memread;

  // Newest value wins: EX match beats MEM.
  always_comb begin
    sel = FWD_RF;
    unique case (1'b1)
      ex_hit:             sel = FWD_MEM;
      mem_hit && !ex_hit: sel = FWD_WB;
      default:            sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall and EX operand forwarding control.
// Ports: clk_i, rst_i (async, low), bus (slave modport).
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  hazard_fwd_ctrl_if.slave bus
);

  stage_rec_t       ex_q;
  stage_rec_t       mem_q;
  stage_rec_t       wb_q;
  stage_rec_t       id_rec;
  logic [1:0]       a_q;
  logic [1:0]       b_q;
  logic [CNT_W-1:0] cnt_q;

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic              hit_a;
  logic              hit_b;
  logic              live;
  logic              stall;
  logic              adv;

  assign rs = bus.id_rs_i;
  assign rt = bus.id_rt_i;

  fwd_match u_match_a (
    .src     (rs),
    .use_src (bus.id_use_rs_i),
    .ex      (ex_q),
    .mem     (mem_q),
    .sel     (sel_a),
    .lu_hit  (hit_a)
  );

  fwd_match u_match_b (
    .src     (rt),
    .use_src (bus.id_use_rt_i),
    .ex      (ex_q),
    .mem     (mem_q),
    .sel     (sel_b),
    .lu_hit  (hit_b)
  );

  // Flush beats stall: a squashed instruction
  // never waits on a load.
  assign live  = bus.id_valid_i & ~bus.flush_i;
  assign stall = live & (hit_a | hit_b);
  assign adv   = live & ~stall;

  always_comb begin
    id_rec          = '0;
    id_rec.valid    = 1'b1;
    id_rec.rd       = bus.id_rd_i;
    id_rec.regwrite = bus.id_regwrite_i;
    id_rec.memread  = bus.id_memread_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      a_q   <= FWD_RF;
      b_q   <= FWD_RF;
      cnt_q <= '0;
    end else begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (adv) begin
        ex_q <= id_rec;
        a_q  <= sel_a;
        b_q  <= sel_b;
      end else begin
        ex_q <= '0;
        a_q  <= FWD_RF;
        b_q  <= FWD_RF;
      end
      if (stall && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // WB is kept for visibility of the full
  // in-flight window; it must trail MEM.
  a_wb_trails_mem: assert property (
    @(posedge clk_i) disable iff (!rst_i)
    wb_q == $past(mem_q)
  );

  assign bus.stall_o     = stall;
  assign bus.fwd_a_sel_o = a_q;
  assign bus.fwd_b_sel_o = b_q;
  assign bus.stall_cnt_o = cnt_q;

endmodule
